// File: rtl/cpu_pkg.sv
// Shared pipeline types: widths, memory-access FSM states and stage bundles.
package cpu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } mem_state_e;

  // EXE/MEM pipeline register contents
  typedef struct packed {
    logic              wb_en;
    logic              mem_r_en;
    logic              mem_w_en;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] val_rm;
  } exe_mem_t;

  // MEM/WB pipeline register contents
  typedef struct packed {
    logic              wb_en;
    logic              mem_r_en;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] mem_data;
  } mem_wb_t;

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory access sequencer: issues req until ack, holds read data,
// and raises freeze while a memory op has not yet reached its DONE cycle.
module mem_access_fsm #(
  parameter int unsigned DATA_W = cpu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_op,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic              freeze,
  output logic [DATA_W-1:0] rdata_held
);
  import cpu_pkg::*;

  mem_state_e        state_q, state_d;
  logic [DATA_W-1:0] rdata_q;

  // State register; async reset abandons any outstanding request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (mem_op) begin
          state_d = mem_ack ? StDone : StBusy;
        end
      end
      StBusy: begin
        if (mem_ack) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs; DONE drops both so the pipeline advances in that cycle
  always_comb begin
    mem_req = 1'b0;
    freeze  = 1'b0;
    unique case (state_q)
      StIdle: begin
        mem_req = mem_op;
        freeze  = mem_op;
      end
      StBusy: begin
        mem_req = 1'b1;
        freeze  = mem_op;
      end
      StDone: begin
        mem_req = 1'b0;
        freeze  = 1'b0;
      end
      default: begin
        mem_req = 1'b0;
        freeze  = 1'b0;
      end
    endcase
  end

  // Capture read data only on an acknowledged request; stray acks are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (mem_req && mem_ack) begin
      rdata_q <= mem_rdata;
    end
  end

  assign rdata_held = rdata_q;

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: EXE/MEM register, data-memory access control and
// MEM/WB register. Freeze holds everything upstream while an access is open.
module mem_stage #(
  parameter int unsigned DATA_W = cpu_pkg::DATA_W,
  parameter int unsigned REG_W  = cpu_pkg::REG_W
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              wbEnExe,
  input  logic              memREnExe,
  input  logic              memWEnExe,
  input  logic [DATA_W-1:0] aluResExe,
  input  logic [DATA_W-1:0] valRmExe,
  input  logic [REG_W-1:0]  destExe,
  output logic              memReq,
  output logic              memWe,
  output logic [DATA_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  input  logic              memAck,
  input  logic [DATA_W-1:0] memRData,
  output logic              freeze,
  output logic              wbEnMem,
  output logic [REG_W-1:0]  destMem,
  output logic [DATA_W-1:0] aluResMem,
  output logic              wbEnWb,
  output logic              memREnWb,
  output logic [REG_W-1:0]  destWb,
  output logic [DATA_W-1:0] aluResWb,
  output logic [DATA_W-1:0] memDataWb
);
  import cpu_pkg::*;

  exe_mem_t          em_q;
  mem_wb_t           wb_q;
  logic              mem_op;
  logic [DATA_W-1:0] rdata_held;

  assign mem_op = em_q.mem_r_en | em_q.mem_w_en;

  // EXE/MEM register: advances whenever the stage is not frozen
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      em_q <= '0;
    end else if (!freeze) begin
      em_q <= '{wb_en:    wbEnExe,
                mem_r_en: memREnExe,
                mem_w_en: memWEnExe,
                dest:     destExe,
                alu_res:  aluResExe,
                val_rm:   valRmExe};
    end
  end

  mem_access_fsm #(
    .DATA_W (DATA_W)
  ) u_access (
    .clk        (clk),
    .rst_n      (rstN),
    .mem_op     (mem_op),
    .mem_ack    (memAck),
    .mem_rdata  (memRData),
    .mem_req    (memReq),
    .freeze     (freeze),
    .rdata_held (rdata_held)
  );

  // MEM/WB register: real instruction when unfrozen, bubble while frozen
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wb_q <= '0;
    end else if (!freeze) begin
      wb_q <= '{wb_en:    em_q.wb_en,
                mem_r_en: em_q.mem_r_en,
                dest:     em_q.dest,
                alu_res:  em_q.alu_res,
                mem_data: rdata_held};
    end else begin
      wb_q.wb_en    <= 1'b0;
      wb_q.mem_r_en <= 1'b0;
    end
  end

  assign memWe     = em_q.mem_w_en;
  assign memAddr   = em_q.alu_res;
  assign memWData  = em_q.val_rm;

  assign wbEnMem   = em_q.wb_en;
  assign destMem   = em_q.dest;
  assign aluResMem = em_q.alu_res;

  assign wbEnWb    = wb_q.wb_en;
  assign memREnWb  = wb_q.mem_r_en;
  assign destWb    = wb_q.dest;
  assign aluResWb  = wb_q.alu_res;
  assign memDataWb = wb_q.mem_data;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: instruction-level model with a stall budget per memory
// op, a memory responder, and a MEM/WB scoreboard monitor.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rstN = 1'b1;
  logic        wbEnExe = 1'b0, memREnExe = 1'b0, memWEnExe = 1'b0;
  logic [31:0] aluResExe = '0, valRmExe = '0;
  logic [3:0]  destExe = '0;
  logic        memReq, memWe, memAck = 1'b0, freeze;
  logic [31:0] memAddr, memWData, memRData = '0;
  logic        wbEnMem, wbEnWb, memREnWb;
  logic [3:0]  destMem, destWb;
  logic [31:0] aluResMem, aluResWb, memDataWb;

  mem_stage dut (
    .clk       (clk),
    .rstN      (rstN),
    .wbEnExe   (wbEnExe),
    .memREnExe (memREnExe),
    .memWEnExe (memWEnExe),
    .aluResExe (aluResExe),
    .valRmExe  (valRmExe),
    .destExe   (destExe),
    .memReq    (memReq),
    .memWe     (memWe),
    .memAddr   (memAddr),
    .memWData  (memWData),
    .memAck    (memAck),
    .memRData  (memRData),
    .freeze    (freeze),
    .wbEnMem   (wbEnMem),
    .destMem   (destMem),
    .aluResMem (aluResMem),
    .wbEnWb    (wbEnWb),
    .memREnWb  (memREnWb),
    .destWb    (destWb),
    .aluResWb  (aluResWb),
    .memDataWb (memDataWb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wb;
    logic        re;
    logic [3:0]  dest;
    logic [31:0] alu;
    logic [31:0] data;
  } wb_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          dly;
  } plan_t;

  int          checks = 0;
  int          errors = 0;
  wb_t         exp_wb[$];
  plan_t       plan[$];
  int          stall = 0;      // edges the upstream must still wait
  logic [31:0] last_rd = '0;   // data the holding register should contain
  logic        cur_wb = 1'b0;  // instruction expected in EXE/MEM
  logic [3:0]  cur_dest = '0;
  logic [31:0] cur_alu = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // One accepted instruction; loops through stalled cycles driving junk
  task automatic cycle(input logic wb, input logic re, input logic we, input logic [3:0] d,
                       input logic [31:0] alu, input logic [31:0] vr, input int dly,
                       input logic [31:0] rd);
    bit done = 1'b0;
    while (!done) begin
      chk("freeze", 32'(freeze), 32'(stall > 0));
      chk("mem_req", 32'(memReq), 32'(stall > 0));
      chk("wb_en_mem", 32'(wbEnMem), 32'(cur_wb));
      chk("dest_mem", 32'(destMem), 32'(cur_dest));
      chk("alu_res_mem", aluResMem, cur_alu);
      if (stall > 0) begin
        wbEnExe   = 1'($urandom);
        memREnExe = 1'($urandom);
        memWEnExe = 1'($urandom);
        destExe   = 4'($urandom);
        aluResExe = $urandom;
        valRmExe  = $urandom;
        @(posedge clk);
        stall--;
        @(negedge clk);
      end else begin
        wbEnExe   = wb;
        memREnExe = re;
        memWEnExe = we;
        destExe   = d;
        aluResExe = alu;
        valRmExe  = vr;
        cur_wb    = wb;
        cur_dest  = d;
        cur_alu   = alu;
        if (re || we) begin
          plan.push_back('{we: we, addr: alu, wdata: vr, rdata: rd, dly: dly});
          last_rd = rd;
          stall   = dly + 1;
        end
        if (wb || re) exp_wb.push_back('{wb: wb, re: re, dest: d, alu: alu, data: last_rd});
        @(posedge clk);
        @(negedge clk);
        done = 1'b1;
      end
    end
  endtask

  task automatic nop();
    cycle(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 0, 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (exp_wb.size() > 0 || stall > 0); i++) nop();
    nop();
    chk("drain_wb", 32'(exp_wb.size()), 32'd0);
    chk("drain_mem", 32'(plan.size()), 32'd0);
  endtask

  // Memory responder: checks each request against the plan, acks after its delay
  plan_t req_cur;
  bit    in_req = 1'b0;
  int    wait_cnt = 0;
  always @(negedge clk) begin
    memAck   = 1'b0;
    memRData = $urandom;
    if (!rstN) begin
      in_req = 1'b0;
    end else if (memReq) begin
      if (!in_req) begin
        if (plan.size() == 0) begin
          chk("unexpected_req", 32'd1, 32'd0);
        end else begin
          req_cur  = plan.pop_front();
          in_req   = 1'b1;
          wait_cnt = req_cur.dly;
        end
      end
      if (in_req) begin
        chk("mem_we", 32'(memWe), 32'(req_cur.we));
        chk("mem_addr", memAddr, req_cur.addr);
        if (req_cur.we) chk("mem_wdata", memWData, req_cur.wdata);
        if (wait_cnt == 0) begin
          memAck   = 1'b1;
          memRData = req_cur.rdata;
          in_req   = 1'b0;
        end else begin
          wait_cnt--;
        end
      end
    end else begin
      if (in_req) chk("req_dropped", 32'd1, 32'd0);
      in_req = 1'b0;
      if ($urandom_range(0, 3) == 0) memAck = 1'b1;  // stray ack, must be ignored
    end
  end

  // Scoreboard monitor on the MEM/WB outputs
  always @(negedge clk) begin
    if (rstN && (wbEnWb || memREnWb)) begin
      if (exp_wb.size() == 0) begin
        chk("wb_unexpected", 32'd1, 32'd0);
      end else begin
        wb_t e;
        e = exp_wb.pop_front();
        chk("wb_en_wb", 32'(wbEnWb), 32'(e.wb));
        chk("mem_r_en_wb", 32'(memREnWb), 32'(e.re));
        chk("dest_wb", 32'(destWb), 32'(e.dest));
        chk("alu_res_wb", aluResWb, e.alu);
        chk("mem_data_wb", memDataWb, e.data);
      end
    end
  end

  logic        r_wb, r_re, r_we;
  logic [3:0]  r_d;
  logic [31:0] r_alu, r_vr, r_rd;
  int          r_k;

  initial begin
    #1 rstN = 1'b0;
    #3;
    chk("rst_mem_req", 32'(memReq), 32'd0);
    chk("rst_freeze", 32'(freeze), 32'd0);
    chk("rst_wb_en_mem", 32'(wbEnMem), 32'd0);
    chk("rst_wb_en_wb", 32'(wbEnWb), 32'd0);
    chk("rst_dest_wb", 32'(destWb), 32'd0);
    chk("rst_alu_res_wb", aluResWb, 32'd0);
    chk("rst_mem_data_wb", memDataWb, 32'd0);
    @(negedge clk);
    rstN = 1'b1;

    // Directed: ALU op, slow load, fast store, back-to-back fast loads
    cycle(1'b1, 1'b0, 1'b0, 4'd3, 32'h10, 32'h0, 0, 32'h0);
    nop();
    nop();
    cycle(1'b1, 1'b1, 1'b0, 4'd5, 32'h40, 32'h0, 3, 32'hDEADBEEF);
    nop();
    cycle(1'b0, 1'b0, 1'b1, 4'd0, 32'h8, 32'h55, 0, 32'h1234);
    cycle(1'b1, 1'b1, 1'b0, 4'd6, 32'h100, 32'h0, 0, 32'hA5A5_0001);
    cycle(1'b1, 1'b1, 1'b0, 4'd7, 32'h104, 32'h0, 0, 32'hA5A5_0002);
    drain();

    // Random mix
    for (int i = 0; i < 300; i++) begin
      r_k   = int'($urandom_range(0, 3));
      r_d   = 4'($urandom);
      r_alu = $urandom;
      r_vr  = $urandom;
      r_rd  = $urandom;
      r_wb  = 1'($urandom);
      r_re  = (r_k == 2);
      r_we  = (r_k == 3);
      if (r_re) r_wb = 1'b1;
      cycle(r_wb, r_re, r_we, r_d, r_alu, r_vr, int'($urandom_range(0, 3)), r_rd);
    end
    drain();

    // Reset in the middle of a long access
    cycle(1'b1, 1'b1, 1'b0, 4'd2, 32'h200, 32'h0, 6, 32'h0BAD_0BAD);
    @(posedge clk);
    #2;
    chk("busy_mem_req", 32'(memReq), 32'd1);
    rstN = 1'b0;
    #1;
    chk("mid_rst_mem_req", 32'(memReq), 32'd0);
    chk("mid_rst_freeze", 32'(freeze), 32'd0);
    chk("mid_rst_wb_en_wb", 32'(wbEnWb), 32'd0);
    chk("mid_rst_dest_mem", 32'(destMem), 32'd0);
    stall    = 0;
    last_rd  = '0;
    cur_wb   = 1'b0;
    cur_dest = '0;
    cur_alu  = '0;
    exp_wb.delete();
    plan.delete();
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    nop();
    cycle(1'b1, 1'b0, 1'b0, 4'd9, 32'h77, 32'h0, 0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 4'd4, 32'h300, 32'h0, 1, 32'hCAFE_F00D);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
